// File: rtl/divm_sched.sv
// Loadable divide-by-M clock generator controller: runs N periods of a divided
// square wave with a per-period tick, then pulses done. Abortable at any time.
module divm_sched #(
  parameter int MW = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [MW-1:0] m_in,
  input  logic [NW-1:0] n_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          clk_out,
  output logic          tick
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [MW-1:0] M_ONE = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] N_ONE = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [MW:0]   H_ONE = {{MW{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [NW-1:0]   n_q, n_d;
  logic [MW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   pcnt_q, pcnt_d;
  logic            err_q, err_d;

  logic            run;
  logic            period_end;
  logic            last_period;
  logic [MW:0]     half_m;

  assign run         = (state_q == S_RUN);
  assign period_end  = (cnt_q == (m_q - M_ONE));
  assign last_period = (pcnt_q == (n_q - N_ONE));
  // ceil(m/2) at MW+1 bits so m = 2^MW-1 does not wrap
  assign half_m      = ({1'b0, m_q} + H_ONE) >> 1;

  assign busy    = run;
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign tick    = run && period_end;
  assign clk_out = run && ({1'b0, cnt_q} < half_m);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if ((m_in != '0) && (n_in != '0)) begin
            m_d     = m_in;
            n_d     = n_in;
            cnt_d   = '0;
            pcnt_d  = '0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // abort takes priority over a coincident final tick
        if (abort) begin
          state_d = S_IDLE;
        end else if (period_end) begin
          cnt_d  = '0;
          pcnt_d = pcnt_q + N_ONE;
          if (last_period) begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + M_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_divm_sched.sv
// Bench for divm_sched: table of directed runs, error/abort/reset sequences,
// and randomized runs compared against a cycle-indexed arithmetic model.
module tb_divm_sched;

  localparam int MW = 16;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [MW-1:0] m_in;
  logic [NW-1:0] n_in;
  logic          busy, done, err, clk_out, tick;

  int checks   = 0;
  int failures = 0;

  divm_sched #(.MW(MW), .NW(NW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .m_in(m_in), .n_in(n_in),
    .busy(busy), .done(done), .err(err), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int n;
    int a;        // cycle during which abort is high (0 = never)
    bit hold;     // keep start high through the whole run
    int exp_done; // expected number of done pulses
  } vec_t;

  typedef struct {
    int m;
    int n;
    bit ab;       // abort together with start
    bit exp_err;
  } evec_t;

  function automatic logic [4:0] outs();
    return {busy, done, err, clk_out, tick};
  endfunction

  // Expected {busy,done,err,clk_out,tick} in cycle t after a start accepted at cycle 0
  function automatic logic [4:0] model(int m, int n, int a, int t);
    int  len;
    bit  aborted;
    bit  act;
    int  pos;
    logic [4:0] r;
    len     = m * n;
    aborted = (a != 0) && (a <= len);
    act     = (t >= 1) && (t <= len) && (!aborted || t <= a);
    pos     = (t >= 1) ? (t - 1) % m : 0;
    r[4] = act;
    r[3] = (t == len + 1) && !aborted;
    r[2] = 1'b0;
    r[1] = act && (pos < (m + 1) / 2);
    r[0] = act && (pos == m - 1);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [4:0] got, logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={busy,done,err,clk_out,tick}=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic run_scn(string tag, int m, int n, int a, bit hold, bit noise, output int ndone);
    int len;
    int last;
    len   = m * n;
    ndone = 0;
    m_in  = MW'(m);
    n_in  = NW'(n);
    start = 1'b1;
    abort = 1'b0;
    step();
    last = hold ? len + 3 : len + 2;
    for (int t = 1; t <= last; t++) begin
      if (hold && t == len + 3)
        chk($sformatf("%s_restart_t%0d", tag, t), outs(), model(m, n, a, 1));
      else
        chk($sformatf("%s_t%0d", tag, t), outs(), model(m, n, a, t));
      if (done) ndone++;
      abort = (t == a);
      if (!hold) begin
        start = 1'b0;
        if (noise && t <= len + 1 && (a == 0 || t <= a))
          start = 1'($urandom);
        if (noise && a == 0 && t == len + 1)
          abort = 1'($urandom);
      end
      if (noise) begin
        m_in = MW'($urandom);
        n_in = NW'($urandom);
      end
      step();
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk($sformatf("%s_idle_after", tag), outs(), 5'b00000);
  endtask

  vec_t  tbl[8];
  evec_t etbl[4];

  initial begin
    int nd;
    int m, n, a;

    tbl[0] = '{m: 4, n: 3, a: 0,  hold: 1'b0, exp_done: 1};
    tbl[1] = '{m: 7, n: 2, a: 0,  hold: 1'b0, exp_done: 1};
    tbl[2] = '{m: 1, n: 5, a: 0,  hold: 1'b1, exp_done: 1};
    tbl[3] = '{m: 4, n: 3, a: 6,  hold: 1'b0, exp_done: 0};
    tbl[4] = '{m: 4, n: 3, a: 12, hold: 1'b0, exp_done: 0};
    tbl[5] = '{m: 2, n: 1, a: 0,  hold: 1'b0, exp_done: 1};
    tbl[6] = '{m: 5, n: 2, a: 1,  hold: 1'b0, exp_done: 0};
    tbl[7] = '{m: 3, n: 2, a: 7,  hold: 1'b0, exp_done: 1};

    etbl[0] = '{m: 0, n: 3, ab: 1'b0, exp_err: 1'b1};
    etbl[1] = '{m: 5, n: 0, ab: 1'b0, exp_err: 1'b1};
    etbl[2] = '{m: 0, n: 0, ab: 1'b1, exp_err: 1'b0};
    etbl[3] = '{m: 6, n: 2, ab: 1'b1, exp_err: 1'b0};

    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    m_in  = '0;
    n_in  = '0;
    #2;
    chk("reset_held", outs(), 5'b00000);
    step();
    step();
    chk("reset_held_clocked", outs(), 5'b00000);
    rstn = 1'b1;
    chk("reset_release", outs(), 5'b00000);
    step();
    chk("idle_after_reset", outs(), 5'b00000);

    for (int i = 0; i < 8; i++) begin
      run_scn($sformatf("vec%0d", i), tbl[i].m, tbl[i].n, tbl[i].a, tbl[i].hold, 1'b0, nd);
      chk_int($sformatf("vec%0d_done_count", i), nd, tbl[i].exp_done);
    end

    for (int i = 0; i < 4; i++) begin
      m_in  = MW'(etbl[i].m);
      n_in  = NW'(etbl[i].n);
      start = 1'b1;
      abort = etbl[i].ab;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("err%0d_next", i), outs(), {2'b00, etbl[i].exp_err, 2'b00});
      step();
      chk($sformatf("err%0d_after", i), outs(), 5'b00000);
    end

    // asynchronous reset in the middle of an m=4, n=3 run
    m_in  = MW'(4);
    n_in  = NW'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      chk($sformatf("rst_run_t%0d", t), outs(), model(4, 3, 0, t));
      if (t < 5) step();
    end
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_async_immediate", outs(), 5'b00000);
    step();
    chk("rst_async_held", outs(), 5'b00000);
    rstn = 1'b1;
    step();
    chk("rst_idle_after", outs(), 5'b00000);
    run_scn("post_rst", 4, 3, 0, 1'b0, 1'b0, nd);
    chk_int("post_rst_done_count", nd, 1);

    for (int r = 0; r < 12; r++) begin
      m = int'($urandom_range(1, 9));
      n = int'($urandom_range(1, 5));
      a = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, m * n));
      run_scn($sformatf("rnd%0d_m%0d_n%0d_a%0d", r, m, n, a), m, n, a, 1'b0, 1'b1, nd);
      chk_int($sformatf("rnd%0d_done_count", r), nd, (a == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divm_sched.md
# divm_sched

Run-time controller for the divide-by-M clock generator. It accepts a divisor M and a period count N via a start handshake, generates exactly N periods of a divided square wave plus a one-cycle tick per period, then reports completion. It sits between user logic (buttons, sequencers, UART timers) and the divided-clock consumers. It replaces a fixed compile-time divisor with a loadable, bounded, abortable one.

## Interface
- MW, 16: width of the divisor M; legal M is 1..2^MW-1.
- NW, 8: width of the period count N; legal N is 1..2^NW-1.

- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  cancel the current run; sampled in every state.
- m_in  input  MW  divisor, latched on an accepted start.
- n_in  input  NW  period count, latched on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the N-th period completes.
- err  output  1  one-cycle pulse when a start is rejected.
- clk_out  output  1  divided square wave; low outside RUN.
- tick  output  1  one-cycle pulse on the last cycle of each period.

## Operation
- Registers:
  - state: IDLE, RUN or DONE.
  - m_r (MW bits) and n_r (NW bits): latched divisor and count.
  - cnt (MW bits): position within the current period.
  - pcnt (NW bits): periods completed.
- Reset (rstn=0, asynchronous): state=IDLE and all registers are 0. busy, done, err, clk_out and tick are all 0 while reset is held and immediately after release.
- IDLE:
  - If start=1, abort=0, m_in≠0 and n_in≠0: latch m_r and n_r, clear cnt and pcnt, go to RUN.
  - If start=1, abort=0 and (m_in=0 or n_in=0): err=1 for the next cycle; stay in IDLE.
  - If abort=1: stay in IDLE regardless of start. Abort wins over start.
- RUN:
  - Each cycle: if cnt=m_r-1 then cnt←0 and pcnt←pcnt+1; otherwise cnt←cnt+1.
  - On the cycle where cnt=m_r-1 and pcnt=n_r-1, go to DONE.
  - If abort=1: go to IDLE next cycle with no done pulse. Abort wins over the final tick in the same cycle.
  - start is ignored; m_in and n_in changes have no effect.
- DONE: lasts exactly one cycle, then IDLE. start is ignored; abort has no visible effect.
- Decodes (combinational from registered state and counters only):
  - busy = (state=RUN).
  - done = (state=DONE).
  - tick = RUN and cnt=m_r-1.
  - clk_out = RUN and cnt < ceil(m_r/2), i.e. cnt < (m_r+1)>>1, computed at MW+1 bits so it cannot overflow.
- Duty cycle: high for ceil(M/2) cycles, then low. For M=1, clk_out stays high and tick fires every cycle during RUN.
- err is a registered one-cycle pulse.

## Timing
- A start accepted at edge k (the IDLE cycle on which start is sampled):
  - busy=1 in cycles k+1 .. k+N·M.
  - cnt=0 in cycle k+1.
  - tick in cycles k+j·M, for j=1..N.
  - done=1 in cycle k+N·M+1, with busy=0 in that cycle.
  - The earliest next start is accepted at edge k+N·M+2.
- Rejected start at edge k: err=1 in cycle k+1; busy stays 0.
- Abort sampled at edge a during RUN: busy=0, clk_out=0 and tick=0 from cycle a+1; no done.
- rstn asserted mid-run: all outputs go to 0 immediately (no clock edge needed); IDLE after release.
- Maximum run length is (2^NW-1)·(2^MW-1) cycles. Counter wrap never occurs because cnt<m_r and pcnt<n_r hold in RUN.

## Test plan
- m=4, n=3, start at cycle 0:
  - ticks at cycles 4, 8, 12;
  - clk_out high at cycles 1-2, 5-6, 9-10;
  - done at cycle 13; busy covers cycles 1-12.
- m=7, n=2 (odd divisor):
  - clk_out high at cycles 1-4 and 8-11;
  - ticks at cycles 7 and 14; done at cycle 15.
- m=1, n=5: tick and clk_out high at cycles 1-5; done at cycle 6; start held high through DONE is not re-accepted until IDLE.
- m=0, n=3 and then m=5, n=0: err pulse one cycle after each start; busy and clk_out stay 0.
- m=4, n=3 with abort at cycle 6: busy=0 from cycle 7, no done. Separately, abort coincident with the final tick at cycle 12 gives no done.
- rstn pulsed low at cycle 5 of an m=4, n=3 run: all outputs 0 during reset, IDLE afterwards, and a fresh start behaves exactly as in the first scenario.
